// File: rtl/trap_ctrl_v2.sv
// Machine-mode trap controller: trap CSRs, exception/interrupt/mret
// arbitration, pipeline flushes and a registered PC redirect.
module trap_ctrl_v2 #(
    parameter int XLEN = 32,
    parameter int NUM_IRQ = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid,
    input  logic               illegal_inst,
    input  logic               ecall_m,
    input  logic               l_access_fault,
    input  logic               s_access_fault,
    input  logic               mret,
    input  logic [31:0]        inst_word,
    input  logic [XLEN-1:0]    fault_addr,
    input  logic [XLEN-1:0]    epc_cur,
    input  logic [XLEN-1:0]    epc_next,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               csr_rw,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               flush_fd,
    output logic               flush_de,
    output logic               flush_em,
    output logic               flush_mw,
    output logic               regwrite_cancel,
    output logic               trap_active
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET} state_t;

    state_t              state_q, state_d;
    logic                st_mie_q, st_mie_d;
    logic                st_mpie_q, st_mpie_d;
    logic [1:0]          st_mpp_q, st_mpp_d;
    logic [NUM_IRQ-1:0]  irq_en_q, irq_en_d;
    logic [XLEN-1:0]     mtvec_q, mtvec_d;
    logic [XLEN-1:0]     mepc_q, mepc_d;
    logic [XLEN-1:0]     mcause_q, mcause_d;
    logic [XLEN-1:0]     mtval_q, mtval_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;

    logic                idle;
    logic                exc_any;
    logic [4:0]          exc_code;
    logic [XLEN-1:0]     exc_tval;
    logic [NUM_IRQ-1:0]  pend;
    logic [4:0]          irq_code;
    logic                take_exc, take_ret, take_irq, take_csr;
    logic [XLEN-1:0]     csr_new;
    logic [XLEN-1:0]     tvec_base;
    logic [XLEN-1:0]     irq_cause;

    assign idle      = (state_q == S_IDLE);
    assign exc_any   = inst_valid & (illegal_inst | ecall_m |
                                     l_access_fault | s_access_fault);
    assign pend      = irq & irq_en_q & {NUM_IRQ{st_mie_q}};
    assign take_exc  = idle & exc_any;
    assign take_ret  = idle & inst_valid & mret & ~exc_any;
    assign take_irq  = idle & (|pend) & ~exc_any & ~take_ret;
    assign take_csr  = idle & csr_rw & (csr_op != 2'b00) &
                       ~(take_exc | take_ret | take_irq);
    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign irq_cause = XLEN'(irq_code) | {1'b1, {(XLEN-1){1'b0}}};

    // Highest-priority synchronous exception and its trap value
    always_comb begin
        exc_code = 5'd7;
        exc_tval = fault_addr;
        if (illegal_inst) begin
            exc_code = 5'd2;
            exc_tval = XLEN'(inst_word);
        end else if (ecall_m) begin
            exc_code = 5'd11;
            exc_tval = '0;
        end else if (l_access_fault) begin
            exc_code = 5'd5;
        end
    end

    // Lowest pending interrupt index wins
    always_comb begin
        irq_code = 5'd16;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) irq_code = 5'(16 + i);
        end
    end

    // Combinational CSR read of the current (pre-write) value
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS: begin
                csr_rdata[3]     = st_mie_q;
                csr_rdata[7]     = st_mpie_q;
                csr_rdata[12:11] = st_mpp_q;
            end
            A_MIE:    csr_rdata[16 +: NUM_IRQ] = irq_en_q;
            A_MIP:    csr_rdata[16 +: NUM_IRQ] = irq;
            A_MTVEC:  csr_rdata = mtvec_q;
            A_MEPC:   csr_rdata = mepc_q;
            A_MCAUSE: csr_rdata = mcause_q;
            A_MTVAL:  csr_rdata = mtval_q;
            default:  csr_rdata = '0;
        endcase
    end

    // Read-modify-write result of the CSR instruction
    always_comb begin
        unique case (csr_op)
            2'b01:   csr_new = csr_wdata;
            2'b10:   csr_new = csr_rdata | csr_wdata;
            2'b11:   csr_new = csr_rdata & ~csr_wdata;
            default: csr_new = csr_rdata;
        endcase
    end

    // Atomic trap / mret / CSR commit and redirect target
    always_comb begin
        st_mie_d         = st_mie_q;
        st_mpie_d        = st_mpie_q;
        st_mpp_d         = st_mpp_q;
        irq_en_d         = irq_en_q;
        mtvec_d          = mtvec_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (take_exc) begin
            mepc_d           = {epc_cur[XLEN-1:2], 2'b00};
            mcause_d         = XLEN'(exc_code);
            mtval_d          = exc_tval;
            st_mpie_d        = st_mie_q;
            st_mie_d         = 1'b0;
            st_mpp_d         = 2'b11;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = tvec_base;
        end else if (take_ret) begin
            st_mie_d         = st_mpie_q;
            st_mpie_d        = 1'b1;
            st_mpp_d         = 2'b11;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mepc_q;
        end else if (take_irq) begin
            mepc_d           = {epc_next[XLEN-1:2], 2'b00};
            mcause_d         = irq_cause;
            mtval_d          = '0;
            st_mpie_d        = st_mie_q;
            st_mie_d         = 1'b0;
            st_mpp_d         = 2'b11;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = (mtvec_q[1:0] == 2'b01)
                             ? tvec_base + XLEN'({irq_code, 2'b00})
                             : tvec_base;
        end else if (take_csr) begin
            case (csr_addr)
                A_MSTATUS: begin
                    st_mie_d  = csr_new[3];
                    st_mpie_d = csr_new[7];
                    st_mpp_d  = csr_new[12:11];
                end
                A_MIE:    irq_en_d = csr_new[16 +: NUM_IRQ];
                A_MTVEC:  mtvec_d  = csr_new[1]
                                   ? {csr_new[XLEN-1:2], 2'b00}
                                   : csr_new;
                A_MEPC:   mepc_d   = {csr_new[XLEN-1:2], 2'b00};
                A_MCAUSE: mcause_d = csr_new;
                A_MTVAL:  mtval_d  = csr_new;
                default:  ;
            endcase
        end
    end

    // State and CSR registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            st_mie_q         <= 1'b0;
            st_mpie_q        <= 1'b0;
            st_mpp_q         <= 2'b11;
            irq_en_q         <= '0;
            mtvec_q          <= RESET_VEC;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            st_mie_q         <= st_mie_d;
            st_mpie_q        <= st_mpie_d;
            st_mpp_q         <= st_mpp_d;
            irq_en_q         <= irq_en_d;
            mtvec_q          <= mtvec_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Next state: one busy cycle after any trap or mret
    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE: begin
                if (take_exc || take_irq) state_d = S_TRAP;
                else if (take_ret)        state_d = S_RET;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flushes: the MEM instruction survives interrupts and mret
    always_comb begin
        flush_fd        = take_exc | take_ret | take_irq;
        flush_de        = take_exc | take_ret | take_irq;
        flush_em        = take_exc | take_ret | take_irq;
        flush_mw        = take_exc;
        regwrite_cancel = take_exc;
        trap_active     = (state_q != S_IDLE);
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule
